// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode classes,
// opcode numbers, mux selects, fault codes and ALU operations.
package ctrl_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  // Instruction class produced by the decode table; steers EXEC/MEM/WB sequencing.
  typedef enum logic [2:0] {
    K_ALU,
    K_LOAD,
    K_STORE,
    K_BRANCH,
    K_JUMP,
    K_ILLEGAL
  } op_kind_t;

  // Opcodes 0..7 are register ALU ops whose ALU code is the low opcode bits.
  localparam int unsigned OP_LSL = 7;
  localparam int unsigned OP_ADI = 8;
  localparam int unsigned OP_SWP = 9;
  localparam int unsigned OP_LDW = 10;
  localparam int unsigned OP_STW = 11;
  localparam int unsigned OP_BRZ = 12;
  localparam int unsigned OP_JAL = 13;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_A_RS    = 2'b00;
  localparam logic [1:0] SRC_A_RS_HI = 2'b10;

  localparam logic [1:0] SRC_B_RT    = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_RT_LO = 2'b10;
  localparam logic [1:0] SRC_B_ZERO  = 2'b11;

  localparam logic [1:0] DST_NONE = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_LINK = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: opcode/flags/handshake in, control strobes out.
interface multicycle_ctrl_if #(
  parameter int unsigned OPC_W   = 4,
  parameter int unsigned ALUOP_W = 3
);
  logic [OPC_W-1:0]   opcode;
  logic               zero;
  logic               mem_ready;
  logic               ir_load;
  logic               pc_en;
  logic [1:0]         pc_src;
  logic               iord;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         reg_dst;
  logic [1:0]         mem_to_reg;
  logic               mem_read;
  logic               mem_write;
  logic               reg_write;
  logic               sign_ext;
  logic [1:0]         fault;
  logic               busy;

  modport master (
    input  opcode, zero, mem_ready,
    output ir_load, pc_en, pc_src, iord, alu_op, alu_src_a, alu_src_b,
           reg_dst, mem_to_reg, mem_read, mem_write, reg_write, sign_ext,
           fault, busy
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ir_load, pc_en, pc_src, iord, alu_op, alu_src_a, alu_src_b,
           reg_dst, mem_to_reg, mem_read, mem_write, reg_write, sign_ext,
           fault, busy
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode table: instruction class plus the ALU controls used in EXEC/MEM.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPC_W   = 4,
  parameter int unsigned ALUOP_W = 3
) (
  input  logic [OPC_W-1:0]   opcode,
  output op_kind_t           kind,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               sign_ext
);

  always_comb begin
    kind      = K_ILLEGAL;
    alu_op    = ALUOP_W'(ALU_ADD);
    alu_src_a = SRC_A_RS;
    alu_src_b = SRC_B_RT;
    sign_ext  = 1'b0;
    if (opcode <= OPC_W'(OP_LSL)) begin
      kind   = K_ALU;
      alu_op = ALUOP_W'(opcode[2:0]);
    end else begin
      case (opcode)
        OPC_W'(OP_ADI): begin
          kind      = K_ALU;
          alu_src_b = SRC_B_IMM;
        end
        OPC_W'(OP_SWP): begin
          kind      = K_ALU;
          alu_src_a = SRC_A_RS_HI;
          alu_src_b = SRC_B_RT_LO;
        end
        OPC_W'(OP_LDW): begin
          kind      = K_LOAD;
          alu_src_b = SRC_B_ZERO;
        end
        OPC_W'(OP_STW): begin
          kind      = K_STORE;
          alu_src_b = SRC_B_ZERO;
        end
        OPC_W'(OP_BRZ): begin
          kind     = K_BRANCH;
          alu_op   = ALUOP_W'(ALU_SUB);
          sign_ext = 1'b1;
        end
        OPC_W'(OP_JAL): kind = K_JUMP;
        default:        kind = K_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM with memory-wait watchdog and sticky fault reporting.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned OPC_W       = 4,
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t             state, state_next;
  logic [OPC_W-1:0]   opcode_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic [1:0]         fault_q, fault_next;
  logic               wait_last;
  op_kind_t           kind;
  logic [ALUOP_W-1:0] dec_alu_op;
  logic [1:0]         dec_src_a, dec_src_b;
  logic               dec_sign_ext;

  ctrl_decode #(.OPC_W(OPC_W), .ALUOP_W(ALUOP_W)) u_decode (
    .opcode    (opcode_q),
    .kind      (kind),
    .alu_op    (dec_alu_op),
    .alu_src_a (dec_src_a),
    .alu_src_b (dec_src_b),
    .sign_ext  (dec_sign_ext)
  );

  assign wait_last = (wait_cnt == WAIT_LAST);

  // Wait counter restarts on every state change, so it is zero on entry to FETCH/MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RESET;
      opcode_q <= '0;
      wait_cnt <= '0;
      fault_q  <= FAULT_NONE;
    end else begin
      state   <= state_next;
      fault_q <= fault_next;
      if (state == ST_FETCH && bus.mem_ready) opcode_q <= bus.opcode;
      if (state_next != state) wait_cnt <= '0;
      else if ((state == ST_FETCH || state == ST_MEM) && !bus.mem_ready)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next     = state;
    fault_next     = fault_q;
    bus.ir_load    = 1'b0;
    bus.pc_en      = 1'b0;
    bus.pc_src     = PC_NEXT;
    bus.iord       = 1'b0;
    bus.alu_op     = '0;
    bus.alu_src_a  = SRC_A_RS;
    bus.alu_src_b  = SRC_B_RT;
    bus.reg_dst    = DST_NONE;
    bus.mem_to_reg = WB_ALU;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.sign_ext   = 1'b0;
    case (state)
      ST_RESET: state_next = ST_FETCH;
      ST_FETCH: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_load = 1'b1;
          state_next  = ST_DECODE;
        end else if (wait_last) begin
          state_next = ST_TRAP;
          fault_next = FAULT_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (kind == K_ILLEGAL) begin
          state_next = ST_TRAP;
          fault_next = FAULT_ILLEGAL;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        bus.alu_op    = dec_alu_op;
        bus.alu_src_a = dec_src_a;
        bus.alu_src_b = dec_src_b;
        bus.sign_ext  = dec_sign_ext;
        case (kind)
          K_LOAD, K_STORE: state_next = ST_MEM;
          K_BRANCH: begin
            bus.pc_en  = 1'b1;
            bus.pc_src = bus.zero ? PC_BRANCH : PC_NEXT;
            state_next = ST_FETCH;
          end
          K_JUMP: begin
            bus.reg_write  = 1'b1;
            bus.reg_dst    = DST_LINK;
            bus.mem_to_reg = WB_LINK;
            bus.pc_en      = 1'b1;
            bus.pc_src     = PC_JUMP;
            state_next     = ST_FETCH;
          end
          default: state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        bus.iord      = 1'b1;
        bus.alu_op    = dec_alu_op;
        bus.alu_src_a = dec_src_a;
        bus.alu_src_b = dec_src_b;
        bus.sign_ext  = dec_sign_ext;
        bus.mem_read  = (kind == K_LOAD);
        bus.mem_write = (kind == K_STORE);
        if (bus.mem_ready) begin
          if (kind == K_STORE) begin
            bus.pc_en  = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (wait_last) begin
          state_next = ST_TRAP;
          fault_next = FAULT_TIMEOUT;
        end
      end
      ST_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = DST_RD;
        bus.mem_to_reg = (kind == K_LOAD) ? WB_MEM : WB_ALU;
        bus.pc_en      = 1'b1;
        state_next     = ST_FETCH;
      end
      ST_TRAP: state_next = ST_TRAP;
      default: state_next = ST_RESET;
    endcase
  end

  assign bus.fault = fault_q;
  assign bus.busy  = (state != ST_FETCH);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed per-scenario bench for multicycle_ctrl: cycle-by-cycle expected control vectors.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       ir_load;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic [2:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       sign_ext;
    logic [1:0] fault;
    logic       busy;
  } ctl_t;

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic       zr;
    logic [3:0] opc;
    ctl_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.OPC_W(4), .ALUOP_W(3)) bus ();

  multicycle_ctrl #(.OPC_W(4), .ALUOP_W(3), .MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  function automatic ctl_t observe();
    ctl_t o;
    o.ir_load    = bus.ir_load;
    o.pc_en      = bus.pc_en;
    o.pc_src     = bus.pc_src;
    o.iord       = bus.iord;
    o.alu_op     = bus.alu_op;
    o.src_a      = bus.alu_src_a;
    o.src_b      = bus.alu_src_b;
    o.reg_dst    = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg;
    o.mem_read   = bus.mem_read;
    o.mem_write  = bus.mem_write;
    o.reg_write  = bus.reg_write;
    o.sign_ext   = bus.sign_ext;
    o.fault      = bus.fault;
    o.busy       = bus.busy;
    return o;
  endfunction

  function automatic ctl_t c_idle(logic busy, logic [1:0] fault);
    ctl_t e = '0;
    e.busy  = busy;
    e.fault = fault;
    return e;
  endfunction

  function automatic ctl_t c_fetch(logic ir);
    ctl_t e = '0;
    e.mem_read = 1'b1;
    e.ir_load  = ir;
    return e;
  endfunction

  function automatic ctl_t c_exec(logic [2:0] alu, logic [1:0] a, logic [1:0] b, logic sx);
    ctl_t e = '0;
    e.busy     = 1'b1;
    e.alu_op   = alu;
    e.src_a    = a;
    e.src_b    = b;
    e.sign_ext = sx;
    return e;
  endfunction

  function automatic ctl_t c_mem(logic rd, logic wr, logic pcen);
    ctl_t e = c_exec(3'b000, 2'b00, 2'b11, 1'b0);
    e.iord      = 1'b1;
    e.mem_read  = rd;
    e.mem_write = wr;
    e.pc_en     = pcen;
    return e;
  endfunction

  function automatic ctl_t c_wb(logic [1:0] m2r);
    ctl_t e = '0;
    e.busy       = 1'b1;
    e.reg_write  = 1'b1;
    e.reg_dst    = 2'b01;
    e.mem_to_reg = m2r;
    e.pc_en      = 1'b1;
    return e;
  endfunction

  function automatic vec_t row(logic r, logic rd, logic z, logic [3:0] op, ctl_t e);
    vec_t v;
    v.rst = r; v.rdy = rd; v.zr = z; v.opc = op; v.e = e;
    return v;
  endfunction

  // Leaves the DUT in RESET at posedge+2 with rst still high.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    vec_t q[$];
    do_reset();
    q.push_back(row(1, 1, 1, 4'h3, c_idle(1, 2'b00)));
    q.push_back(row(1, 1, 0, 4'h3, c_idle(1, 2'b00)));
    q.push_back(row(0, 0, 0, 4'h0, c_idle(1, 2'b00)));
    q.push_back(row(0, 0, 0, 4'h0, c_fetch(0)));
    q.push_back(row(0, 0, 0, 4'h0, c_fetch(0)));
    foreach (q[i]) begin
      rst = q[i].rst; bus.mem_ready = q[i].rdy; bus.zero = q[i].zr; bus.opcode = q[i].opc;
      #1;
      checks++;
      if (observe() !== q[i].e) begin
        errors++;
        $display("FAIL reset[%0d]: got %h expected %h", i, observe(), q[i].e);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_alu_ops();
    vec_t q[$];
    logic [3:0] ops [4] = '{4'd0, 4'd5, 4'd8, 4'd9};
    logic [2:0] alu [4] = '{3'b000, 3'b101, 3'b000, 3'b000};
    logic [1:0] sa  [4] = '{2'b00, 2'b00, 2'b00, 2'b10};
    logic [1:0] sb  [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    do_reset();
    q.push_back(row(0, 1, 0, 4'h0, c_idle(1, 2'b00)));
    for (int k = 0; k < 4; k++) begin
      q.push_back(row(0, 1, 0, ops[k], c_fetch(1)));
      q.push_back(row(0, 1, 0, 4'hF, c_idle(1, 2'b00)));
      q.push_back(row(0, 1, 1, 4'hF, c_exec(alu[k], sa[k], sb[k], 1'b0)));
      q.push_back(row(0, 0, 0, 4'hF, c_wb(2'b00)));
    end
    q.push_back(row(0, 0, 0, 4'h0, c_fetch(0)));
    foreach (q[i]) begin
      rst = q[i].rst; bus.mem_ready = q[i].rdy; bus.zero = q[i].zr; bus.opcode = q[i].opc;
      #1;
      checks++;
      if (observe() !== q[i].e) begin
        errors++;
        $display("FAIL alu_ops[%0d]: got %h expected %h", i, observe(), q[i].e);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_load();
    vec_t q[$];
    do_reset();
    q.push_back(row(0, 1, 0, 4'h0, c_idle(1, 2'b00)));
    q.push_back(row(0, 1, 0, 4'hA, c_fetch(1)));
    q.push_back(row(0, 0, 0, 4'h0, c_idle(1, 2'b00)));
    q.push_back(row(0, 0, 0, 4'h0, c_exec(3'b000, 2'b00, 2'b11, 1'b0)));
    for (int k = 0; k < 3; k++) q.push_back(row(0, 0, 0, 4'h0, c_mem(1, 0, 0)));
    q.push_back(row(0, 1, 0, 4'h0, c_mem(1, 0, 0)));
    q.push_back(row(0, 0, 0, 4'h0, c_wb(2'b01)));
    q.push_back(row(0, 0, 0, 4'h0, c_fetch(0)));
    foreach (q[i]) begin
      rst = q[i].rst; bus.mem_ready = q[i].rdy; bus.zero = q[i].zr; bus.opcode = q[i].opc;
      #1;
      checks++;
      if (observe() !== q[i].e) begin
        errors++;
        $display("FAIL load[%0d]: got %h expected %h", i, observe(), q[i].e);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_store();
    vec_t q[$];
    do_reset();
    q.push_back(row(0, 1, 0, 4'h0, c_idle(1, 2'b00)));
    q.push_back(row(0, 1, 0, 4'hB, c_fetch(1)));
    q.push_back(row(0, 0, 0, 4'h0, c_idle(1, 2'b00)));
    q.push_back(row(0, 0, 0, 4'h0, c_exec(3'b000, 2'b00, 2'b11, 1'b0)));
    q.push_back(row(0, 0, 0, 4'h0, c_mem(0, 1, 0)));
    q.push_back(row(0, 1, 0, 4'h0, c_mem(0, 1, 1)));
    q.push_back(row(0, 1, 0, 4'hB, c_fetch(1)));
    q.push_back(row(0, 0, 0, 4'h0, c_idle(1, 2'b00)));
    q.push_back(row(0, 0, 0, 4'h0, c_exec(3'b000, 2'b00, 2'b11, 1'b0)));
    q.push_back(row(1, 1, 0, 4'h0, c_mem(0, 1, 1)));
    q.push_back(row(0, 1, 0, 4'h0, c_idle(1, 2'b00)));
    q.push_back(row(0, 0, 0, 4'h0, c_fetch(0)));
    foreach (q[i]) begin
      rst = q[i].rst; bus.mem_ready = q[i].rdy; bus.zero = q[i].zr; bus.opcode = q[i].opc;
      #1;
      checks++;
      if (observe() !== q[i].e) begin
        errors++;
        $display("FAIL store[%0d]: got %h expected %h", i, observe(), q[i].e);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_branch_jump();
    vec_t q[$];
    ctl_t e;
    do_reset();
    q.push_back(row(0, 1, 0, 4'h0, c_idle(1, 2'b00)));
    q.push_back(row(0, 1, 0, 4'hC, c_fetch(1)));
    q.push_back(row(0, 1, 0, 4'h0, c_idle(1, 2'b00)));
    e = c_exec(3'b001, 2'b00, 2'b00, 1'b1); e.pc_en = 1'b1; e.pc_src = 2'b01;
    q.push_back(row(0, 1, 1, 4'h0, e));
    q.push_back(row(0, 1, 0, 4'hC, c_fetch(1)));
    q.push_back(row(0, 1, 1, 4'h0, c_idle(1, 2'b00)));
    e = c_exec(3'b001, 2'b00, 2'b00, 1'b1); e.pc_en = 1'b1; e.pc_src = 2'b00;
    q.push_back(row(0, 1, 0, 4'h0, e));
    q.push_back(row(0, 1, 0, 4'hD, c_fetch(1)));
    q.push_back(row(0, 1, 0, 4'h0, c_idle(1, 2'b00)));
    e = c_idle(1, 2'b00); e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
    e.pc_en = 1'b1; e.pc_src = 2'b10;
    q.push_back(row(0, 0, 0, 4'h0, e));
    q.push_back(row(0, 0, 0, 4'h0, c_fetch(0)));
    foreach (q[i]) begin
      rst = q[i].rst; bus.mem_ready = q[i].rdy; bus.zero = q[i].zr; bus.opcode = q[i].opc;
      #1;
      checks++;
      if (observe() !== q[i].e) begin
        errors++;
        $display("FAIL branch_jump[%0d]: got %h expected %h", i, observe(), q[i].e);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_illegal();
    vec_t q[$];
    do_reset();
    q.push_back(row(0, 1, 0, 4'h0, c_idle(1, 2'b00)));
    q.push_back(row(0, 1, 0, 4'hE, c_fetch(1)));
    q.push_back(row(0, 1, 0, 4'h0, c_idle(1, 2'b00)));
    for (int k = 0; k < 20; k++)
      q.push_back(row(0, k[0], k[1], 4'(k), c_idle(1, 2'b01)));
    q.push_back(row(1, 1, 0, 4'h0, c_idle(1, 2'b01)));
    q.push_back(row(0, 0, 0, 4'h0, c_idle(1, 2'b00)));
    q.push_back(row(0, 0, 0, 4'h0, c_fetch(0)));
    foreach (q[i]) begin
      rst = q[i].rst; bus.mem_ready = q[i].rdy; bus.zero = q[i].zr; bus.opcode = q[i].opc;
      #1;
      checks++;
      if (observe() !== q[i].e) begin
        errors++;
        $display("FAIL illegal[%0d]: got %h expected %h", i, observe(), q[i].e);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_fetch_timeout();
    vec_t q[$];
    do_reset();
    q.push_back(row(0, 0, 0, 4'h0, c_idle(1, 2'b00)));
    for (int k = 0; k < 15; k++) q.push_back(row(0, 0, 0, 4'h0, c_fetch(0)));
    q.push_back(row(0, 1, 0, 4'h0, c_idle(1, 2'b10)));
    q.push_back(row(1, 1, 0, 4'h0, c_idle(1, 2'b10)));
    q.push_back(row(0, 0, 0, 4'h0, c_idle(1, 2'b00)));
    for (int k = 0; k < 14; k++) q.push_back(row(0, 0, 0, 4'h0, c_fetch(0)));
    q.push_back(row(0, 1, 0, 4'h0, c_fetch(1)));
    q.push_back(row(0, 0, 0, 4'h0, c_idle(1, 2'b00)));
    q.push_back(row(0, 0, 0, 4'h0, c_exec(3'b000, 2'b00, 2'b00, 1'b0)));
    q.push_back(row(0, 0, 0, 4'h0, c_wb(2'b00)));
    foreach (q[i]) begin
      rst = q[i].rst; bus.mem_ready = q[i].rdy; bus.zero = q[i].zr; bus.opcode = q[i].opc;
      #1;
      checks++;
      if (observe() !== q[i].e) begin
        errors++;
        $display("FAIL fetch_timeout[%0d]: got %h expected %h", i, observe(), q[i].e);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_mem_timeout();
    vec_t q[$];
    do_reset();
    q.push_back(row(0, 1, 0, 4'h0, c_idle(1, 2'b00)));
    q.push_back(row(0, 1, 0, 4'hA, c_fetch(1)));
    q.push_back(row(0, 0, 0, 4'h0, c_idle(1, 2'b00)));
    q.push_back(row(0, 0, 0, 4'h0, c_exec(3'b000, 2'b00, 2'b11, 1'b0)));
    for (int k = 0; k < 15; k++) q.push_back(row(0, 0, 0, 4'h0, c_mem(1, 0, 0)));
    q.push_back(row(0, 1, 0, 4'h0, c_idle(1, 2'b10)));
    q.push_back(row(0, 1, 0, 4'hA, c_idle(1, 2'b10)));
    foreach (q[i]) begin
      rst = q[i].rst; bus.mem_ready = q[i].rdy; bus.zero = q[i].zr; bus.opcode = q[i].opc;
      #1;
      checks++;
      if (observe() !== q[i].e) begin
        errors++;
        $display("FAIL mem_timeout[%0d]: got %h expected %h", i, observe(), q[i].e);
      end
      @(posedge clk); #2;
    end
  endtask

  initial begin
    bus.opcode    = 4'h0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_alu_ops();
    test_load();
    test_store();
    test_branch_jump();
    test_illegal();
    test_fetch_timeout();
    test_mem_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
